// File: rtl/phase_timing_gen.sv
// phase_timing_gen: CP clock pulse and N one-hot phase strobes with debounced start/stop/step buttons.
// Optional build macro PHASE_GAP_EN: in RUN, each strobe is high only during the CP-high half of its slot.
module phase_timing_gen #(
    parameter int N_PHASES        = 4,
    parameter int CLK_DIV         = 25000000,
    parameter int DEBOUNCE_CYCLES = 10000
) (
    input  logic                sys_clk_in,
    input  logic                sys_rst_n,
    input  logic                enable,
    input  logic                mode_single,
    input  logic                btn_start,
    input  logic                btn_stop,
    input  logic                btn_step,
    output logic                cp_out,
    output logic [N_PHASES-1:0] phase_out,
    output logic                running,
    output logic                cycle_done,
    output logic [7:0]          cycle_count
);
    localparam int PW = $clog2(N_PHASES);
    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [PW-1:0] PH_LAST  = PW'(N_PHASES - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] DB_LAST  = BW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          w_btn_raw;
    logic [2:0]          r_sync1;
    logic [2:0]          r_sync2;
    logic [2:0]          r_accepted;
    logic [2:0]          r_press;
    logic [BW-1:0]       r_db_cnt [3];
    logic [DW-1:0]       r_div;
    logic                r_half;
    logic [PW-1:0]       r_phase;
    logic                r_cycle_done;
    logic [7:0]          r_count;
    logic                w_start;
    logic                w_stop;
    logic                w_step;
    logic                w_go;
    logic                w_tick;
    logic                w_run_adv;
    logic                w_cycle_end;
    logic [N_PHASES-1:0] w_onehot;

    function automatic logic [PW-1:0] next_phase(input logic [PW-1:0] ph);
        return (ph == PH_LAST) ? '0 : ph + 1'b1;
    endfunction

    assign w_btn_raw = {btn_step, btn_stop, btn_start};

    // Buttons are active-low: a press is an accepted 1->0 transition after a stable run of DEBOUNCE_CYCLES.
    always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1    <= '1;
            r_sync2    <= '1;
            r_accepted <= '1;
            r_press    <= '0;
            for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            r_press <= '0;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] != r_accepted[i]) begin
                    if (r_db_cnt[i] == DB_LAST) begin
                        r_accepted[i] <= r_sync2[i];
                        r_db_cnt[i]   <= '0;
                        r_press[i]    <= ~r_sync2[i];
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_start  = r_press[0];
    assign w_stop   = r_press[1];
    assign w_step   = r_press[2];
    assign w_go     = enable & ~w_stop;
    assign w_tick   = (r_div == DIV_LAST);
    // A start in RUN is a no-op but still outranks step, so the slot keeps advancing.
    assign w_run_adv   = (r_state == S_RUN) & w_go & (w_start | ~w_step);
    assign w_cycle_end = w_run_adv & w_tick & r_half & (r_phase == PH_LAST);
    assign w_onehot    = {{(N_PHASES-1){1'b0}}, 1'b1} << r_phase;

    always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    if (w_start)     w_state_nxt = S_RUN;
                    else if (w_step) w_state_nxt = S_HOLD;
                end
            end
            S_RUN: begin
                if (!w_go)                            w_state_nxt = S_IDLE;
                else if (!w_start && w_step)          w_state_nxt = S_HOLD;
                else if (w_cycle_end && mode_single)  w_state_nxt = S_IDLE;
            end
            S_HOLD: begin
                if (!w_go)        w_state_nxt = S_IDLE;
                else if (w_start) w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Divider, half-slot flag and phase index; divider only moves in RUN so HOLD freezes it.
    always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_div        <= '0;
            r_half       <= 1'b0;
            r_phase      <= '0;
            r_cycle_done <= 1'b0;
            r_count      <= '0;
        end else begin
            r_cycle_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_div   <= '0;
                    r_half  <= 1'b0;
                    r_phase <= '0;
                end
                S_RUN: begin
                    if (w_run_adv) begin
                        if (w_tick) begin
                            r_div  <= '0;
                            r_half <= ~r_half;
                            if (r_half) r_phase <= next_phase(r_phase);
                        end else begin
                            r_div <= r_div + 1'b1;
                        end
                        if (w_cycle_end) begin
                            r_cycle_done <= 1'b1;
                            r_count      <= r_count + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_go) begin
                        if (w_start) begin
                            r_div  <= '0;
                            r_half <= 1'b0;
                        end else if (w_step) begin
                            r_phase <= next_phase(r_phase);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cp_out    = 1'b0;
        phase_out = '0;
        running   = 1'b0;
        case (r_state)
            S_RUN: begin
                running = 1'b1;
                cp_out  = ~r_half;
`ifdef PHASE_GAP_EN
                if (!r_half) phase_out = w_onehot;
`else
                phase_out = w_onehot;
`endif
            end
            S_HOLD:  phase_out = w_onehot;
            default: ;
        endcase
    end

    assign cycle_done  = r_cycle_done;
    assign cycle_count = r_count;

endmodule
